// File: rtl/serdes_pkg.sv
// Shared SERDES symbol constants and TX SKP inserter state type.
package serdes_pkg;

    localparam int unsigned SYM_W = 10;

    // COM+SKP clock-compensation pair, also recognised by the RX elastic buffer
    localparam logic [SYM_W-1:0] SKP_SYM1 = 10'h0f9;
    localparam logic [SYM_W-1:0] SKP_SYM2 = 10'h306;

    typedef enum logic [0:0] {
        PASS = 1'b0,
        SKP  = 1'b1
    } tx_skp_state_e;

endpackage

// File: rtl/skp_interval_timer.sv
// Counts output symbol loads and pulses accrue_c on the load that completes an interval.
module skp_interval_timer #(
    parameter int unsigned SKP_INTERVAL = 354
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic accrue_c
);

    localparam int unsigned CNT_W = $clog2(SKP_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SKP_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Advance on each load; wrap and pulse accrue at the last position
    always_comb begin
        cnt_d    = cnt_q;
        accrue_c = 1'b0;
        if (tick) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d    = '0;
                accrue_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Interval counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_skp_inserter.sv
// Inserts COM+SKP pairs into the TX symbol stream at packet boundaries.
module tx_skp_inserter
    import serdes_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 354,
    parameter int unsigned OWED_WIDTH   = 4
) (
    input  logic                  lclk,
    input  logic                  lrst_n,
    input  logic                  skp_en,
    input  logic [SYM_W-1:0]      data_in,
    input  logic                  data_in_vld,
    input  logic                  data_in_last,
    output logic                  data_in_rdy,
    input  logic                  out_rdy,
    output logic [SYM_W-1:0]      data_out,
    output logic                  data_out_vld,
    output logic [OWED_WIDTH-1:0] skp_owed,
    output logic                  skp_overflow
);

    localparam logic [OWED_WIDTH-1:0] OWED_MAX = '1;

    tx_skp_state_e         state_q, state_d;
    logic [SYM_W-1:0]      data_out_q, data_out_d;
    logic                  data_out_vld_q, data_out_vld_d;
    logic [OWED_WIDTH-1:0] skp_owed_q, skp_owed_d;
    logic                  skp_overflow_q, skp_overflow_d;
    logic                  at_boundary_q, at_boundary_d;

    logic adv_c;
    logic skp_due_c;
    logic load_c;
    logic dec_c;
    logic rdy_c;
    logic accrue_c;

    skp_interval_timer #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_timer (
        .clk      (lclk),
        .rst_n    (lrst_n),
        .tick     (load_c),
        .accrue_c (accrue_c)
    );

    // Next-state and output-register selection; a started pair always completes
    always_comb begin
        state_d        = state_q;
        data_out_d     = data_out_q;
        data_out_vld_d = data_out_vld_q;
        at_boundary_d  = at_boundary_q;
        load_c         = 1'b0;
        dec_c          = 1'b0;
        rdy_c          = 1'b0;
        adv_c          = !data_out_vld_q || out_rdy;
        skp_due_c      = at_boundary_q && (skp_owed_q != '0) && skp_en;

        if (adv_c) begin
            case (state_q)
                PASS: begin
                    if (skp_due_c) begin
                        data_out_d     = SKP_SYM1;
                        data_out_vld_d = 1'b1;
                        load_c         = 1'b1;
                        state_d        = SKP;
                    end else begin
                        rdy_c = 1'b1;
                        if (data_in_vld) begin
                            data_out_d     = data_in;
                            data_out_vld_d = 1'b1;
                            at_boundary_d  = data_in_last;
                            load_c         = 1'b1;
                        end else begin
                            data_out_vld_d = 1'b0;
                        end
                    end
                end
                SKP: begin
                    data_out_d     = SKP_SYM2;
                    data_out_vld_d = 1'b1;
                    load_c         = 1'b1;
                    dec_c          = 1'b1;
                    state_d        = PASS;
                end
                default: begin
                    state_d = PASS;
                end
            endcase
        end
    end

    // Owed-pair bookkeeping: accrual and completed pair cancel when coincident
    always_comb begin
        skp_owed_d     = skp_owed_q;
        skp_overflow_d = skp_overflow_q;
        if (accrue_c && !dec_c) begin
            if (skp_owed_q == OWED_MAX) begin
                skp_overflow_d = 1'b1;
            end else begin
                skp_owed_d = skp_owed_q + OWED_WIDTH'(1);
            end
        end else if (dec_c && !accrue_c) begin
            skp_owed_d = skp_owed_q - OWED_WIDTH'(1);
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge lclk) begin
        if (!lrst_n) begin
            state_q        <= PASS;
            data_out_q     <= '0;
            data_out_vld_q <= 1'b0;
            skp_owed_q     <= '0;
            skp_overflow_q <= 1'b0;
            at_boundary_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            data_out_q     <= data_out_d;
            data_out_vld_q <= data_out_vld_d;
            skp_owed_q     <= skp_owed_d;
            skp_overflow_q <= skp_overflow_d;
            at_boundary_q  <= at_boundary_d;
        end
    end

    assign data_in_rdy  = lrst_n && rdy_c;
    assign data_out     = data_out_q;
    assign data_out_vld = data_out_vld_q;
    assign skp_owed     = skp_owed_q;
    assign skp_overflow = skp_overflow_q;

endmodule

// File: tb/tb_tx_skp_inserter.sv
// Randomised bench for tx_skp_inserter against a load-count based reference model.
module tb_tx_skp_inserter;
    import serdes_pkg::*;

    localparam int unsigned INTV = 8;
    localparam int unsigned OW   = 2;
    localparam int          OMAX = (1 << OW) - 1;

    logic          lclk = 1'b0;
    logic          lrst_n;
    logic          skp_en;
    logic [9:0]    data_in;
    logic          data_in_vld;
    logic          data_in_last;
    logic          data_in_rdy;
    logic          out_rdy;
    logic [9:0]    data_out;
    logic          data_out_vld;
    logic [OW-1:0] skp_owed;
    logic          skp_overflow;

    always #5 lclk = ~lclk;

    tx_skp_inserter #(
        .SKP_INTERVAL (INTV),
        .OWED_WIDTH   (OW)
    ) dut (
        .lclk         (lclk),
        .lrst_n       (lrst_n),
        .skp_en       (skp_en),
        .data_in      (data_in),
        .data_in_vld  (data_in_vld),
        .data_in_last (data_in_last),
        .data_in_rdy  (data_in_rdy),
        .out_rdy      (out_rdy),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .skp_owed     (skp_owed),
        .skp_overflow (skp_overflow)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: total loads since reset decide accrual; pairs tracked as "second half due"
    bit         m_known = 1'b0;
    int         m_loads;
    int         m_owed;
    bit         m_ovf;
    bit         m_vld;
    logic [9:0] m_out;
    bit         m_sym2_due;
    bit         m_bnd;

    // Upstream packet source
    logic [9:0] src_seq  = 10'd1;
    int         src_left = 1;
    int         pkt_len  = 1;
    bit         cap_en   = 1'b0;
    logic [9:0] cap[$];

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_rdy();
        return (lrst_n === 1'b1) && !m_sym2_due && (!m_vld || (out_rdy === 1'b1))
               && !(m_bnd && (m_owed > 0) && (skp_en === 1'b1));
    endfunction

    // Advance the model by one clock edge; returns 1 when an upstream symbol was taken
    function automatic bit m_update();
        bit loaded = 1'b0;
        bit dec    = 1'b0;
        bit acc    = 1'b0;
        bit took   = 1'b0;
        if (lrst_n !== 1'b1) begin
            m_known    = 1'b1;
            m_loads    = 0;
            m_owed     = 0;
            m_ovf      = 1'b0;
            m_vld      = 1'b0;
            m_out      = 10'd0;
            m_sym2_due = 1'b0;
            m_bnd      = 1'b1;
            return 1'b0;
        end
        if (m_vld && (out_rdy !== 1'b1)) return 1'b0;
        if (m_sym2_due) begin
            m_out      = SKP_SYM2;
            m_sym2_due = 1'b0;
            dec        = 1'b1;
            loaded     = 1'b1;
        end else if (m_bnd && (m_owed > 0) && (skp_en === 1'b1)) begin
            m_out      = SKP_SYM1;
            m_sym2_due = 1'b1;
            loaded     = 1'b1;
        end else if (data_in_vld === 1'b1) begin
            m_out  = data_in;
            m_bnd  = data_in_last;
            loaded = 1'b1;
            took   = 1'b1;
        end
        m_vld = loaded;
        if (loaded) begin
            m_loads++;
            acc = ((m_loads % INTV) == 0);
        end
        if (acc && !dec) begin
            if (m_owed == OMAX) m_ovf = 1'b1;
            else m_owed++;
        end else if (dec && !acc) begin
            m_owed--;
        end
        return took;
    endfunction

    function automatic void src_next_len();
        src_left = (pkt_len > 0) ? pkt_len : int'($urandom_range(1, 12));
    endfunction

    // One clock: drive inputs, compare away from the edge, then step model and source
    task automatic cycle(int vld_pct, int rdy_pct, int en_pct);
        data_in      = src_seq;
        data_in_last = (src_left == 1);
        data_in_vld  = (int'($urandom_range(0, 99)) < vld_pct);
        out_rdy      = (int'($urandom_range(0, 99)) < rdy_pct);
        skp_en       = (int'($urandom_range(0, 99)) < en_pct);
        @(negedge lclk);
        if (m_known) begin
            chk("data_out_vld", int'(data_out_vld), int'(m_vld));
            if (m_vld) chk("data_out", int'(data_out), int'(m_out));
            chk("skp_owed", int'(skp_owed), m_owed);
            chk("skp_overflow", int'(skp_overflow), int'(m_ovf));
        end
        if (data_in_vld) chk("data_in_rdy", int'(data_in_rdy), int'(m_rdy()));
        if (cap_en && (data_out_vld === 1'b1)) cap.push_back(data_out);
        @(posedge lclk);
        if (m_update()) begin
            src_seq  = src_seq + 10'd1;
            src_left = src_left - 1;
            if (src_left == 0) src_next_len();
        end
        #1;
    endtask

    task automatic do_reset();
        lrst_n = 1'b0;
        cycle(100, 100, 100);
        lrst_n  = 1'b1;
        src_seq = 10'd1;
        src_next_len();
    endtask

    logic [9:0] exp1[13];
    logic [9:0] exp2[10];

    initial begin
        int k;
        lrst_n       = 1'b0;
        skp_en       = 1'b0;
        data_in      = 10'd0;
        data_in_vld  = 1'b0;
        data_in_last = 1'b0;
        out_rdy      = 1'b0;
        #1;

        // Single-symbol packets: pair after the 8th output, nothing lost or reordered
        pkt_len = 1;
        do_reset();
        chk("rst_vld", int'(data_out_vld), 0);
        chk("rst_owed", int'(skp_owed), 0);
        chk("rst_data", int'(data_out), 0);
        exp1 = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008,
                 10'h0f9, 10'h306, 10'h009, 10'h00a, 10'h00b};
        cap.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 14; i++) cycle(100, 100, 100);
        cap_en = 1'b0;
        for (int i = 0; i < 13; i++)
            chk("p1_seq", (i < cap.size()) ? int'(cap[i]) : -1, int'(exp1[i]));

        // 30-symbol packet: owed builds to 3; flush crosses load 32, whose accrual extends it to 4 pairs
        pkt_len = 30;
        do_reset();
        for (int i = 0; i < 30; i++) cycle(100, 100, 100);
        chk("p2_owed_at_end", int'(skp_owed), 3);
        chk("p2_last_sym", int'(data_out), 30);
        exp2 = '{10'd30, 10'h0f9, 10'h306, 10'h0f9, 10'h306,
                 10'h0f9, 10'h306, 10'h0f9, 10'h306, 10'd31};
        cap.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 10; i++) cycle(100, 100, 100);
        cap_en = 1'b0;
        for (int i = 0; i < 10; i++)
            chk("p2_flush", (i < cap.size()) ? int'(cap[i]) : -1, int'(exp2[i]));
        chk("p2_owed_after", int'(skp_owed), 1);

        // 40-symbol packet: saturation at 3, sticky overflow
        pkt_len = 40;
        do_reset();
        for (int i = 0; i < 40; i++) cycle(100, 100, 100);
        chk("p3_owed_sat", int'(skp_owed), 3);
        chk("p3_overflow", int'(skp_overflow), 1);
        for (int i = 0; i < 30; i++) cycle(100, 100, 100);
        chk("p3_overflow_sticky", int'(skp_overflow), 1);

        // Reset right after SKP_SYM1 loads: pair dropped, passthrough resumes
        pkt_len = 1;
        do_reset();
        k = 0;
        while (!m_sym2_due && k < 40) begin
            cycle(100, 100, 100);
            k++;
        end
        chk("p4_sym1_seen", int'(m_sym2_due), 1);
        chk("p4_sym1_out", int'(data_out), int'(SKP_SYM1));
        lrst_n = 1'b0;
        cycle(100, 100, 100);
        lrst_n = 1'b1;
        chk("p4_vld_after_rst", int'(data_out_vld), 0);
        chk("p4_owed_after_rst", int'(skp_owed), 0);
        for (int i = 0; i < 20; i++) cycle(100, 100, 100);

        // Randomised traffic with backpressure, skp_en toggling and rare resets
        pkt_len = 0;
        src_next_len();
        for (int i = 0; i < 4000; i++) begin
            lrst_n = (int'($urandom_range(0, 999)) >= 3);
            cycle(75, 60, 85);
        end
        lrst_n = 1'b1;
        for (int i = 0; i < 20; i++) cycle(100, 100, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
